i2s_tx_fifo: RTL and testbench
==============================

Name: i2s_tx_fifo

Overview:
Dual-channel transmit sample buffer between the CPU register interface (DOUT1R/DOUT0R writes) and the codec serial interface (aud_din0/aud_din1 with aud_din_ack).
- Holds one 16-entry FIFO per channel.
- Formats each 32-bit CPU word into a 24-bit MSB-aligned codec sample, per the LCFR fields octet_cnt, rjust and lsb_first.
- Produces the TX status flags (txe, txnf, tx_unf) used by SR/interrupt logic.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth per channel (16 entries)
DATA_W, 32, CPU write word width
SAMPLE_W, 24, codec sample width

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
txen  input  1  transmit enable (CR.txen)
octet_cnt  input  3  significant bytes per word; 1..3 valid; 0 or >3 treated as 3
rjust  input  1  1: sample in word LSBs; 0: sample in word MSBs
lsb_first  input  1  1: bit-reverse significant bits before alignment
wr0_en  input  1  push wr0_data into channel 0 FIFO
wr0_data  input  32  channel 0 word
wr1_en  input  1  push wr1_data into channel 1 FIFO
wr1_data  input  32  channel 1 word
unf_clr  input  1  clear sticky underrun flags (CR.irq_rst)
aud_din_ack  input  2  codec consumed sample on channel [n] this cycle
aud_din0  output  24  channel 0 sample presented to codec
aud_din1  output  24  channel 1 sample presented to codec
txe  output  2  channel FIFO empty
txnf  output  2  channel FIFO not full
tx_unf  output  2  sticky underrun per channel
wr_drop  output  2  one-cycle pulse: write to full FIFO discarded
level0  output  5  channel 0 occupancy, 0..16
level1  output  5  channel 1 occupancy, 0..16

Behaviour:
- Reset values (asynchronous): all pointers 0; txe=2'b11; txnf=2'b11; tx_unf=0; wr_drop=0; aud_din0=aud_din1=0; levels 0. FIFO memory is not reset.
- Pointers: head and tail are DEPTH_LOG2+1 bits wide, with a wrap bit.
  - empty = (head==tail).
  - full = indices equal and wrap bits differ.
  - level = head-tail, modulo 2^(DEPTH_LOG2+1).
- Write:
  - wrN_en while not full: mem[head] <= data; head increments at the edge.
  - wrN_en while full: word discarded, head unchanged, wr_drop[N]=1 for the next cycle.
  - Accepted regardless of txen.
- Read:
  - aud_dinN is combinational: format(mem[tail]) when txen=1 and not empty, else 24'h0.
  - Codec samples aud_dinN in the cycle aud_din_ack[N]=1. Tail increments at that edge.
  - Zero latency: the next word is visible the cycle after the ack.
- Underrun:
  - aud_din_ack[N] while empty and txen=1: tail unchanged, 0 delivered, tx_unf[N] set at the edge.
  - unf_clr clears both bits. If a new underrun occurs in the same cycle as unf_clr, set wins.
- txen=0:
  - Acks are ignored: no pop, no underrun.
  - FIFO contents are retained.
- Simultaneous write and ack, same channel:
  - Empty FIFO: the ack underruns (no bypass) and the write lands; level becomes 1.
  - Full FIFO: both the pop and the push happen; level stays 16; no drop.
- Wrap-around: indices wrap modulo 16 and the wrap bit toggles. No other special handling.
- Formatting, with n = effective octet_cnt (1..3) and w = the 32-bit word:
  - Extract: s = rjust ? w[8n-1:0] : w[31:32-8n].
  - If lsb_first=1, reverse the 8n bits of s.
  - Output = s << (24-8n). Low bits are 0.
- Format inputs are sampled live, with no retiming. Software changes them only while txen=0.
- Flags txe, txnf and level are combinational from the pointers. wr_drop and tx_unf are registered.

Decomposition:
- Shared package cbi980_pkg holds:
  - register address constants (CVR..DIN0R);
  - FIFO_DEPTH_LOG2=4 and SAMPLE_W=24;
  - OCTET_MAX=3;
  - SR/CR flag bit indices, so that core and block agree.
- Sub-module i2s_chan_fifo is one channel: memory, pointers, flags, underrun/drop logic. It is instantiated twice.
- The formatter is a function in the package, shared by both instances.

Test Plan:
- Reset, then write ch0 words 0x11223344 and 0xAABBCCDD with txen=1, octet_cnt=3, rjust=0, lsb_first=0. Then ack[0] twice. Required: aud_din0 = 0x112233, then 0xAABBCC, then 0; txe[0]=1; tx_unf[0]=0.
- octet_cnt=2, rjust=1, word 0x0000BEEF. Required: aud_din0=0xBEEF00. Set lsb_first=1. Required: aud_din0=0xF77D00.
- Write 17 words to ch1 (values 0..16). Required: level1=16 and txnf[1]=0 after the 16th; wr_drop[1] pulses after the 17th. Popping 16 times returns 0..15 in order, exercising pointer wrap.
- With ch0 empty and txen=1, assert ack[0]. Required: tx_unf[0]=1, aud_din0=0. Assert unf_clr in the same cycle as a second empty ack. Required: tx_unf[0] stays 1. Assert unf_clr alone. Required: tx_unf[0]=0.
- txen=0, ch0 holds 3 words, assert ack[0] 5 times. Required: level0 stays 3, aud_din0=0, no underrun.
- ch0 full with simultaneous wr0_en and ack[0]: level stays 16, no drop. Assert rst mid-stream: immediately txe=2'b11, aud_din0=0, level0=0.

Source files
------------

// File: rtl/cbi980_pkg.sv
// cbi980_pkg
//   Shared definitions for the CBI980 audio block and its core glue logic:
//   register map, FIFO geometry, status/control bit positions, and the
//   CPU-word to codec-sample formatter used by both transmit channels.
package cbi980_pkg;

   // Register byte addresses, in map order CVR..DIN0R
   localparam logic [7:0] CVR    = 8'h00;
   localparam logic [7:0] CR     = 8'h04;
   localparam logic [7:0] SR     = 8'h08;
   localparam logic [7:0] IER    = 8'h0C;
   localparam logic [7:0] LCFR   = 8'h10;
   localparam logic [7:0] DOUT1R = 8'h14;
   localparam logic [7:0] DOUT0R = 8'h18;
   localparam logic [7:0] DIN1R  = 8'h1C;
   localparam logic [7:0] DIN0R  = 8'h20;

   // FIFO and sample geometry
   localparam int FIFO_DEPTH_LOG2 = 4;
   localparam int DATA_W          = 32;
   localparam int SAMPLE_W        = 24;
   localparam int OCTET_MAX       = 3;

   // CR bit positions
   localparam int CR_TXEN    = 0;
   localparam int CR_RXEN    = 1;
   localparam int CR_IRQ_RST = 2;

   // SR bit positions (two bits per flag: [ch1, ch0])
   localparam int SR_TXE_LO    = 0;
   localparam int SR_TXNF_LO   = 2;
   localparam int SR_TX_UNF_LO = 4;

   // Converts one CPU word into an MSB-aligned codec sample.
   // The significant bytes are first gathered into the low bits of s; a
   // full 24-bit reversal then both bit-reverses them and moves them to
   // the top, so the lsb_first path needs no separate shift.
   function automatic logic [SAMPLE_W-1:0] fmt_sample(
      input logic [DATA_W-1:0] w,
      input logic [2:0]        octet_cnt,
      input logic              rjust,
      input logic              lsb_first
   );
      logic [2:0]          n;
      logic [SAMPLE_W-1:0] s;
      logic [SAMPLE_W-1:0] r;
      n = octet_cnt;
      if (octet_cnt == 3'd0 || octet_cnt > 3'(OCTET_MAX)) begin
         n = 3'(OCTET_MAX);
      end
      case (n)
         3'd1:    s = rjust ? {16'h0, w[7:0]}  : {16'h0, w[31:24]};
         3'd2:    s = rjust ? {8'h0,  w[15:0]} : {8'h0,  w[31:16]};
         default: s = rjust ? w[23:0]          : w[31:8];
      endcase
      r = '0;
      if (lsb_first) begin
         for (int i = 0; i < SAMPLE_W; i++) begin
            r[i] = s[SAMPLE_W-1-i];
         end
      end else begin
         case (n)
            3'd1:    r = s << 16;
            3'd2:    r = s << 8;
            default: r = s;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/i2s_chan_fifo.sv
// i2s_chan_fifo
//   One transmit channel: sample memory, head/tail pointers with wrap bit,
//   status flags, sticky underrun and write-drop pulse.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   txen                transmit enable; gates pops, underruns and dout
//   octet_cnt/rjust/lsb_first  live formatting controls
//   wr_en, wr_data      CPU push
//   unf_clr             clears the sticky underrun flag
//   ack                 codec consumed the presented sample
//   dout                formatted sample at the tail (0 when idle/empty)
//   empty, not_full     occupancy flags
//   unf                 sticky underrun
//   drop                one-cycle pulse after a discarded write
//   level               occupancy 0..DEPTH
module i2s_chan_fifo
   import cbi980_pkg::*;
#(
   parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  txen,
   input  logic [2:0]            octet_cnt,
   input  logic                  rjust,
   input  logic                  lsb_first,
   input  logic                  wr_en,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  unf_clr,
   input  logic                  ack,
   output logic [SAMPLE_W-1:0]   dout,
   output logic                  empty,
   output logic                  not_full,
   output logic                  unf,
   output logic                  drop,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DEPTH_LOG2:0] head_q, head_d;
   logic [DEPTH_LOG2:0] tail_q, tail_d;
   logic                unf_q, unf_d;
   logic                drop_q, drop_d;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   rd_word;

   logic full;
   logic pop;
   logic push;
   logic underrun;

   assign empty    = (head_q == tail_q);
   assign full     = (head_q[DEPTH_LOG2-1:0] == tail_q[DEPTH_LOG2-1:0]) &&
                     (head_q[DEPTH_LOG2] != tail_q[DEPTH_LOG2]);
   assign not_full = !full;
   assign level    = head_q - tail_q;

   // An ack on an empty FIFO never bypasses a same-cycle write.
   assign pop      = ack && txen && !empty;
   assign underrun = ack && txen && empty;
   // A full FIFO still accepts a write when the same cycle frees a slot.
   assign push     = wr_en && (!full || pop);

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      unf_d  = unf_q;
      drop_d = wr_en && full && !pop;
      if (push) begin
         head_d = head_q + (DEPTH_LOG2+1)'(1);
      end
      if (pop) begin
         tail_d = tail_q + (DEPTH_LOG2+1)'(1);
      end
      // A new underrun takes priority over the clear.
      if (underrun) begin
         unf_d = 1'b1;
      end else if (unf_clr) begin
         unf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         unf_q  <= 1'b0;
         drop_q <= 1'b0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         unf_q  <= unf_d;
         drop_q <= drop_d;
      end
   end

   // Sample storage carries no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[head_q[DEPTH_LOG2-1:0]] <= wr_data;
      end
   end

   // Read is asynchronous so the next word is presented the cycle after an ack.
   assign rd_word = mem[tail_q[DEPTH_LOG2-1:0]];
   assign dout    = (txen && !empty) ?
                    fmt_sample(rd_word, octet_cnt, rjust, lsb_first) : '0;
   assign unf     = unf_q;
   assign drop    = drop_q;

endmodule

// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo
//   Dual-channel transmit sample buffer between the CPU DOUTnR writes and
//   the codec serial interface.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   txen                        transmit enable
//   octet_cnt, rjust, lsb_first sample formatting controls
//   wr0_en/wr0_data, wr1_en/wr1_data   per-channel pushes
//   unf_clr                     clears both sticky underrun flags
//   aud_din_ack[1:0]            codec consumed channel sample
//   aud_din0, aud_din1          formatted samples to codec
//   txe, txnf, tx_unf, wr_drop  per-channel status [ch1, ch0]
//   level0, level1              per-channel occupancy
module i2s_tx_fifo
   import cbi980_pkg::*;
#(
   parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  txen,
   input  logic [2:0]            octet_cnt,
   input  logic                  rjust,
   input  logic                  lsb_first,
   input  logic                  wr0_en,
   input  logic [DATA_W-1:0]     wr0_data,
   input  logic                  wr1_en,
   input  logic [DATA_W-1:0]     wr1_data,
   input  logic                  unf_clr,
   input  logic [1:0]            aud_din_ack,
   output logic [SAMPLE_W-1:0]   aud_din0,
   output logic [SAMPLE_W-1:0]   aud_din1,
   output logic [1:0]            txe,
   output logic [1:0]            txnf,
   output logic [1:0]            tx_unf,
   output logic [1:0]            wr_drop,
   output logic [DEPTH_LOG2:0]   level0,
   output logic [DEPTH_LOG2:0]   level1
);

   logic                wr_en_a   [2];
   logic [DATA_W-1:0]   wr_data_a [2];
   logic [SAMPLE_W-1:0] dout_a    [2];
   logic [DEPTH_LOG2:0] level_a   [2];

   assign wr_en_a[0]   = wr0_en;
   assign wr_en_a[1]   = wr1_en;
   assign wr_data_a[0] = wr0_data;
   assign wr_data_a[1] = wr1_data;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         i2s_chan_fifo #(
            .DEPTH_LOG2 (DEPTH_LOG2)
         ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .txen      (txen),
            .octet_cnt (octet_cnt),
            .rjust     (rjust),
            .lsb_first (lsb_first),
            .wr_en     (wr_en_a[gi]),
            .wr_data   (wr_data_a[gi]),
            .unf_clr   (unf_clr),
            .ack       (aud_din_ack[gi]),
            .dout      (dout_a[gi]),
            .empty     (txe[gi]),
            .not_full  (txnf[gi]),
            .unf       (tx_unf[gi]),
            .drop      (wr_drop[gi]),
            .level     (level_a[gi])
         );
      end
   endgenerate

   assign aud_din0 = dout_a[0];
   assign aud_din1 = dout_a[1];
   assign level0   = level_a[0];
   assign level1   = level_a[1];

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// tb_i2s_tx_fifo
//   Directed scenarios followed by randomized traffic, all checked against a
//   queue-based reference model of the two transmit channels.
module tb_i2s_tx_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        txen;
   logic [2:0]  octet_cnt;
   logic        rjust;
   logic        lsb_first;
   logic        wr0_en;
   logic [31:0] wr0_data;
   logic        wr1_en;
   logic [31:0] wr1_data;
   logic        unf_clr;
   logic [1:0]  aud_din_ack;
   logic [23:0] aud_din0;
   logic [23:0] aud_din1;
   logic [1:0]  txe;
   logic [1:0]  txnf;
   logic [1:0]  tx_unf;
   logic [1:0]  wr_drop;
   logic [4:0]  level0;
   logic [4:0]  level1;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference model state
   logic [31:0] mq [2][$];
   bit          m_unf  [2];
   bit          m_drop [2];

   always #5 clk = ~clk;

   i2s_tx_fifo dut (
      .clk         (clk),
      .rst         (rst),
      .txen        (txen),
      .octet_cnt   (octet_cnt),
      .rjust       (rjust),
      .lsb_first   (lsb_first),
      .wr0_en      (wr0_en),
      .wr0_data    (wr0_data),
      .wr1_en      (wr1_en),
      .wr1_data    (wr1_data),
      .unf_clr     (unf_clr),
      .aud_din_ack (aud_din_ack),
      .aud_din0    (aud_din0),
      .aud_din1    (aud_din1),
      .txe         (txe),
      .txnf        (txnf),
      .tx_unf      (tx_unf),
      .wr_drop     (wr_drop),
      .level0      (level0),
      .level1      (level1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      if (obs !== exp_v) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   // Sample formatting from the written rules, using integer arithmetic.
   function automatic logic [23:0] ref_fmt(input logic [31:0] w, input int oc,
                                           input bit rj, input bit lf);
      int n;
      int bits;
      longint unsigned s;
      longint unsigned r;
      n = (oc < 1 || oc > 3) ? 3 : oc;
      bits = 8 * n;
      if (rj) s = longint'(w) % (64'd1 << bits);
      else    s = longint'(w) >> (32 - bits);
      if (lf) begin
         r = 0;
         for (int i = 0; i < bits; i++) begin
            if (((s >> i) & 1) != 0) r = r | (64'd1 << (bits - 1 - i));
         end
         s = r;
      end
      return 24'(s << (24 - bits));
   endfunction

   function automatic logic [23:0] exp_din(input int ch);
      if (txen && mq[ch].size() > 0)
         return ref_fmt(mq[ch][0], int'(octet_cnt), rjust, lsb_first);
      return 24'h0;
   endfunction

   task automatic check_model();
      chk("din0",    {8'h0, aud_din0}, {8'h0, exp_din(0)});
      chk("din1",    {8'h0, aud_din1}, {8'h0, exp_din(1)});
      chk("txe",     {30'h0, txe},     {30'h0, mq[1].size() == 0, mq[0].size() == 0});
      chk("txnf",    {30'h0, txnf},    {30'h0, mq[1].size() < 16, mq[0].size() < 16});
      chk("tx_unf",  {30'h0, tx_unf},  {30'h0, m_unf[1], m_unf[0]});
      chk("wr_drop", {30'h0, wr_drop}, {30'h0, m_drop[1], m_drop[0]});
      chk("level0",  {27'h0, level0},  32'(mq[0].size()));
      chk("level1",  {27'h0, level1},  32'(mq[1].size()));
   endtask

   task automatic model_edge();
      bit          w   [2];
      logic [31:0] d   [2];
      bit          pop;
      bit          full;
      w[0] = wr0_en; w[1] = wr1_en;
      d[0] = wr0_data; d[1] = wr1_data;
      for (int ch = 0; ch < 2; ch++) begin
         full = (mq[ch].size() == 16);
         pop  = aud_din_ack[ch] && txen && mq[ch].size() > 0;
         if (aud_din_ack[ch] && txen && mq[ch].size() == 0) m_unf[ch] = 1'b1;
         else if (unf_clr)                                  m_unf[ch] = 1'b0;
         if (pop) void'(mq[ch].pop_front());
         m_drop[ch] = w[ch] && full && !pop;
         if (w[ch] && (!full || pop)) mq[ch].push_back(d[ch]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      $display("[TB] cyc %0d txen=%b wr=%b%b ack=%b clr=%b lvl=%0d/%0d unf=%b drop=%b",
               cyc, txen, wr1_en, wr0_en, aud_din_ack, unf_clr, level1, level0, tx_unf, wr_drop);
      cyc++;
      wr0_en = 1'b0; wr1_en = 1'b0; aud_din_ack = 2'b00; unf_clr = 1'b0;
   endtask

   task automatic cycle(input bit w0, input logic [31:0] d0, input bit w1,
                        input logic [31:0] d1, input logic [1:0] ack, input bit clr);
      wr0_en = w0; wr0_data = d0;
      wr1_en = w1; wr1_data = d1;
      aud_din_ack = ack; unf_clr = clr;
      #1;
      check_model();
      tick();
   endtask

   task automatic model_reset();
      mq[0].delete(); mq[1].delete();
      m_unf[0] = 0; m_unf[1] = 0; m_drop[0] = 0; m_drop[1] = 0;
   endtask

   initial begin
      rst = 1'b1; txen = 1'b0; octet_cnt = 3'd3; rjust = 1'b0; lsb_first = 1'b0;
      wr0_en = 1'b0; wr0_data = '0; wr1_en = 1'b0; wr1_data = '0;
      unf_clr = 1'b0; aud_din_ack = 2'b00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_txe",   {30'h0, txe},  32'h3);
      chk("rst_txnf",  {30'h0, txnf}, 32'h3);
      chk("rst_level", {27'h0, level0}, 32'h0);
      check_model();
      rst = 1'b0;
      #1;

      // Basic MSB-justified 3-octet flow
      txen = 1'b1;
      cycle(1, 32'h11223344, 0, 0, 2'b00, 0);
      cycle(1, 32'hAABBCCDD, 0, 0, 2'b00, 0);
      chk("t1_din_a", {8'h0, aud_din0}, 32'h112233);
      cycle(0, 0, 0, 0, 2'b01, 0);
      chk("t1_din_b", {8'h0, aud_din0}, 32'hAABBCC);
      cycle(0, 0, 0, 0, 2'b01, 0);
      chk("t1_din_c", {8'h0, aud_din0}, 32'h0);
      chk("t1_txe0",  {31'h0, txe[0]}, 32'h1);
      chk("t1_unf0",  {31'h0, tx_unf[0]}, 32'h0);

      // Right-justified 2-octet, then bit reversal
      octet_cnt = 3'd2; rjust = 1'b1;
      cycle(1, 32'h0000BEEF, 0, 0, 2'b00, 0);
      chk("t2_rjust", {8'h0, aud_din0}, 32'hBEEF00);
      lsb_first = 1'b1;
      #1;
      chk("t2_lsbf",  {8'h0, aud_din0}, 32'hF77D00);
      cycle(0, 0, 0, 0, 2'b01, 0);
      lsb_first = 1'b0; octet_cnt = 3'd3;

      // Fill ch1 past full, then drain through the wrap
      for (int i = 0; i < 17; i++) begin
         cycle(0, 0, 1, 32'(i), 2'b00, 0);
         if (i == 15) begin
            chk("t3_level16", {27'h0, level1}, 32'd16);
            chk("t3_txnf1",   {31'h0, txnf[1]}, 32'h0);
         end
      end
      chk("t3_drop1", {31'h0, wr_drop[1]}, 32'h1);
      for (int i = 0; i < 16; i++) begin
         chk("t3_pop", {8'h0, aud_din1}, 32'(i));
         cycle(0, 0, 0, 0, 2'b10, 0);
      end
      chk("t3_empty1", {31'h0, txe[1]}, 32'h1);
      rjust = 1'b0;

      // Underrun and clear priority
      cycle(0, 0, 0, 0, 2'b01, 0);
      chk("t4_unf_set", {31'h0, tx_unf[0]}, 32'h1);
      chk("t4_din0",    {8'h0, aud_din0}, 32'h0);
      cycle(0, 0, 0, 0, 2'b01, 1);
      chk("t4_set_wins", {31'h0, tx_unf[0]}, 32'h1);
      cycle(0, 0, 0, 0, 2'b00, 1);
      chk("t4_cleared", {31'h0, tx_unf[0]}, 32'h0);

      // Acks ignored while disabled
      for (int i = 0; i < 3; i++) cycle(1, 32'hC0DE0000 + 32'(i), 0, 0, 2'b00, 0);
      txen = 1'b0;
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 2'b01, 0);
      chk("t5_level3", {27'h0, level0}, 32'd3);
      chk("t5_din0",   {8'h0, aud_din0}, 32'h0);
      chk("t5_nounf",  {31'h0, tx_unf[0]}, 32'h0);

      // Full FIFO with simultaneous push and pop
      txen = 1'b1;
      for (int i = 0; i < 13; i++) cycle(1, $urandom, 0, 0, 2'b00, 0);
      chk("t6_full", {27'h0, level0}, 32'd16);
      cycle(1, 32'h5A5A5A5A, 0, 0, 2'b01, 0);
      chk("t6_level16", {27'h0, level0}, 32'd16);
      chk("t6_nodrop",  {31'h0, wr_drop[0]}, 32'h0);

      // Asynchronous reset between edges
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_txe",   {30'h0, txe}, 32'h3);
      chk("t6_rst_din0",  {8'h0, aud_din0}, 32'h0);
      chk("t6_rst_level", {27'h0, level0}, 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_model();

      // Randomized traffic with phases biased toward fill or drain
      for (int i = 0; i < 800; i++) begin
         int wp;
         wp = ((i / 100) % 2 == 0) ? 75 : 30;
         if ($urandom_range(0, 39) == 0) begin
            txen = ~txen;
            if (!txen) begin
               octet_cnt = 3'($urandom_range(0, 7));
               rjust     = 1'($urandom_range(0, 1));
               lsb_first = 1'($urandom_range(0, 1));
            end
         end
         cycle($urandom_range(0, 99) < wp, $urandom,
               $urandom_range(0, 99) < wp, $urandom,
               {$urandom_range(0, 99) < (100 - wp), $urandom_range(0, 99) < (100 - wp)},
               $urandom_range(0, 19) == 0);
      end
      #1;
      check_model();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
